if_fetch_ctrl: RTL and testbench
================================

Name: if_fetch_ctrl

Overview:
- Fetch-stage controller for the 5-stage 16-bit pipelined RISC core. It owns the PC register, the instruction-memory request handshake, a 1-entry hold buffer and the IF/ID pipeline register.
- It is the consumer of the hazard unit's stall pair (pause_pc, wrt_IF_ID) and of the EX-stage branch flush.
- It issues requests to the instruction cache, which may stall for several cycles. It delivers instructions, or NOP bubbles, to ID.

Parameters:
- PC_W, 16, width of PC and addresses
- INSTR_W, 16, instruction width
- RESET_PC, 16'h0000, PC value after reset
- NOP_INSTR, 16'h0800, encoding inserted for bubbles
- HALT_OP, 5'b00000, opcode in instr[15:11] that stops fetch

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- pause_pc  in  1  hazard unit: hold PC, start no new fetch
- wrt_IF_ID  in  1  hazard unit: 1 = IF/ID may be written, 0 = hold IF/ID
- flush  in  1  branch/jump resolved taken in EX
- br_target  in  PC_W  redirect address, valid with flush
- imem_rdy  in  1  cache: imem_instr valid this cycle, request complete
- imem_instr  in  INSTR_W  fetched instruction
- imem_req  out  1  fetch request, held until imem_rdy
- imem_addr  out  PC_W  fetch address, stable while imem_req=1
- instr_IF_ID  out  INSTR_W  IF/ID instruction
- pc2_IF_ID  out  PC_W  IF/ID PC+2 of that instruction
- valid_IF_ID  out  1  IF/ID holds a real instruction
- halted  out  1  fetch stopped on HALT

Behaviour:
- Reset, when rst_n=0 at an edge:
  - pc=RESET_PC, state=FETCH, hold_valid=0.
  - instr_IF_ID=NOP_INSTR, pc2_IF_ID=0, valid_IF_ID=0, halted=0.
  - imem_req is forced 0 while rst_n=0.
  - Reset aborts any in-flight request: a response arriving after reset is ignored unless a new request has been issued.
- States are FETCH, WAIT, DRAIN and HALT.
- FETCH:
  - imem_req = ~pause_pc & ~hold_valid; imem_addr = pc.
  - If req & imem_rdy: the response is accepted this cycle.
  - If req & ~imem_rdy: latch the outstanding address and go to WAIT.
- WAIT:
  - imem_req=1 at the latched address, independent of pause_pc.
  - On imem_rdy: accept the response and return to FETCH.
- Accepting a response:
  - pc <= pc+2, modulo 2^PC_W, so 16'hFFFE wraps to 16'h0000.
  - The instruction goes to IF/ID if IF/ID is being written from it this cycle (wrt_IF_ID=1 and hold buffer empty). Otherwise it goes to the hold buffer together with its pc+2.
  - If instr[15:11]==HALT_OP, the next state is HALT and pc is not advanced. The HALT itself is still delivered.
- IF/ID write occurs only when wrt_IF_ID=1 and flush=0. Source priority:
  1. hold buffer, which is then cleared;
  2. response accepted this cycle;
  3. bubble: NOP_INSTR, valid=0.
- IF/ID hold: when wrt_IF_ID=0, IF/ID is unchanged. A response arriving in that cycle goes to the hold buffer.
- pause_pc and wrt_IF_ID gate independently. 2'b10 is a load-use stall, 2'b01 is normal flow, and 00/11 are legal.
- flush has priority over everything:
  - IF/ID <= bubble, hold_valid <= 0, pc <= br_target, halted <= 0.
  - If state is WAIT and imem_rdy=0: go to DRAIN with the old address held.
  - Otherwise, go to FETCH. A same-cycle response is discarded.
- DRAIN:
  - imem_req=1 at the old address.
  - On imem_rdy: discard the data, no pc change, go to FETCH. A new fetch starts the next cycle.
  - A second flush in DRAIN updates pc only.
- HALT:
  - imem_req=0, halted=1.
  - IF/ID drains the hold buffer, then bubbles.
  - HALT is left only by flush (wrong-path HALT) or reset.
- There is never more than one outstanding request. imem_addr never changes while imem_req=1 and imem_rdy=0.

Test Plan:
- Reset, then imem_rdy tied 1 with instrs A,B,C at 0,2,4 -> IF/ID shows A/pc2=2, B/4, C/6 on consecutive cycles, all valid=1.
- Load-use stall: (pause_pc,wrt_IF_ID)=2'b10 for 1 cycle while B is in IF/ID -> B and pc held one extra cycle, imem_req=0 that cycle, no instruction lost or duplicated.
- Cache miss: imem_rdy=0 for 4 cycles at addr 16'h0010 -> imem_req=1 and addr=0x0010 stable, IF/ID bubbles (valid=0, NOP), instruction delivered on the 5th cycle.
- Response during hold: wrt_IF_ID=0 in the cycle imem_rdy=1 -> instruction goes to the hold buffer, pc advances, imem_req=0 next cycle, buffered instruction enters IF/ID in the first cycle with wrt_IF_ID=1.
- Flush mid-miss: flush with br_target=16'h0040 at WAIT cycle 2 -> DRAIN, the old response is discarded, then fetch from 0x0040, IF/ID bubble. Also test flush with a non-empty hold buffer -> buffer cleared.
- HALT fetched at 0x0008 -> delivered once, halted=1, pc stays 0x0008, imem_req=0 thereafter. Then flush to 0x0020 -> halted=0 and fetch resumes at 0x0020. Then reset mid-WAIT -> all reset values restored.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage controller: PC, imem handshake, 1-entry hold buffer
// and the IF/ID pipeline register for the 16-bit RISC core.
module if_fetch_ctrl #(
    parameter int                 PC_W      = 16,
    parameter int                 INSTR_W   = 16,
    parameter logic [PC_W-1:0]    RESET_PC  = 16'h0000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]         HALT_OP   = 5'b00000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pause_pc,
    input  logic               wrt_IF_ID,
    input  logic               flush,
    input  logic [PC_W-1:0]    br_target,
    input  logic               imem_rdy,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    output logic [INSTR_W-1:0] instr_IF_ID,
    output logic [PC_W-1:0]    pc2_IF_ID,
    output logic               valid_IF_ID,
    output logic               halted
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DRAIN,
        S_HALT
    } state_t;

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(2);

    state_t             state;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    out_addr;
    logic               hold_valid;
    logic [INSTR_W-1:0] hold_instr;
    logic [PC_W-1:0]    hold_pc2;

    logic               accept;
    logic               resp_halt;
    logic [PC_W-1:0]    resp_pc2;
    logic               ifid_wr;

    // Request generation: a miss or drain keeps the request up regardless of pause
    always_comb begin
        imem_req = 1'b0;
        unique case (state)
            S_FETCH: imem_req = ~pause_pc & ~hold_valid;
            S_WAIT:  imem_req = 1'b1;
            S_DRAIN: imem_req = 1'b1;
            S_HALT:  imem_req = 1'b0;
        endcase
        if (!rst_n) begin
            imem_req = 1'b0;
        end
    end

    assign imem_addr = (state == S_FETCH) ? pc : out_addr;
    assign accept    = imem_req & imem_rdy & ((state == S_FETCH) | (state == S_WAIT));
    assign resp_halt = (imem_instr[INSTR_W-1 -: 5] == HALT_OP);
    assign resp_pc2  = imem_addr + PC_STEP;
    assign ifid_wr   = wrt_IF_ID & ~flush;

    // Fetch FSM, PC, hold buffer and IF/ID register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            out_addr    <= RESET_PC;
            hold_valid  <= 1'b0;
            hold_instr  <= NOP_INSTR;
            hold_pc2    <= '0;
            instr_IF_ID <= NOP_INSTR;
            pc2_IF_ID   <= '0;
            valid_IF_ID <= 1'b0;
            halted      <= 1'b0;
        end else if (flush) begin
            pc          <= br_target;
            hold_valid  <= 1'b0;
            instr_IF_ID <= NOP_INSTR;
            valid_IF_ID <= 1'b0;
            halted      <= 1'b0;
            // An unanswered request must still be drained at its old address
            if (((state == S_WAIT) || (state == S_DRAIN)) && !imem_rdy) begin
                state <= S_DRAIN;
            end else begin
                state <= S_FETCH;
            end
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (imem_req && !imem_rdy) begin
                        out_addr <= pc;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                end
                S_DRAIN: begin
                    if (imem_rdy) begin
                        state <= S_FETCH;
                    end
                end
                S_HALT: begin
                end
            endcase

            if (accept) begin
                if (resp_halt) begin
                    state  <= S_HALT;
                    halted <= 1'b1;
                end else begin
                    pc    <= pc + PC_STEP;
                    state <= S_FETCH;
                end
            end

            if (ifid_wr) begin
                if (hold_valid) begin
                    instr_IF_ID <= hold_instr;
                    pc2_IF_ID   <= hold_pc2;
                    valid_IF_ID <= 1'b1;
                    hold_valid  <= 1'b0;
                end else if (accept) begin
                    instr_IF_ID <= imem_instr;
                    pc2_IF_ID   <= resp_pc2;
                    valid_IF_ID <= 1'b1;
                end else begin
                    instr_IF_ID <= NOP_INSTR;
                    valid_IF_ID <= 1'b0;
                end
            end

            // A response that cannot go straight to IF/ID is parked
            if (accept && !(ifid_wr && !hold_valid)) begin
                hold_valid <= 1'b1;
                hold_instr <= imem_instr;
                hold_pc2   <= resp_pc2;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_if_fetch_ctrl;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pause_pc;
    logic        wrt_IF_ID;
    logic        flush;
    logic [15:0] br_target;
    logic        imem_rdy;
    logic [15:0] imem_instr;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] instr_IF_ID;
    logic [15:0] pc2_IF_ID;
    logic        valid_IF_ID;
    logic        halted;

    logic [15:0] mem [0:255];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr[8:1]];

    if_fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pause_pc    (pause_pc),
        .wrt_IF_ID   (wrt_IF_ID),
        .flush       (flush),
        .br_target   (br_target),
        .imem_rdy    (imem_rdy),
        .imem_instr  (imem_instr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .instr_IF_ID (instr_IF_ID),
        .pc2_IF_ID   (pc2_IF_ID),
        .valid_IF_ID (valid_IF_ID),
        .halted      (halted)
    );

    // Reference model: outstanding-request bookkeeping plus a FIFO of parked words
    logic [15:0] m_pc;
    bit          m_out;
    bit          m_stale;
    logic [15:0] m_oaddr;
    logic [31:0] m_hold [$];
    bit          m_halted;
    logic [15:0] m_instr;
    logic [15:0] m_pc2;
    bit          m_valid;

    function automatic bit exp_req();
        if (!rst_n) return 1'b0;
        if (m_out) return 1'b1;
        if (m_halted) return 1'b0;
        return !pause_pc && (m_hold.size() == 0);
    endfunction

    function automatic logic [15:0] exp_addr();
        return m_out ? m_oaddr : m_pc;
    endfunction

    task automatic model_edge();
        bit          req;
        bit          got;
        bit          acc;
        logic [15:0] a;
        logic [15:0] d;
        if (!rst_n) begin
            m_pc = 16'h0000; m_out = 0; m_stale = 0;
            m_hold.delete(); m_halted = 0;
            m_instr = NOP; m_pc2 = 16'h0000; m_valid = 0;
            return;
        end
        req = exp_req();
        a   = exp_addr();
        d   = mem[a[8:1]];
        got = req && imem_rdy;
        if (flush) begin
            m_instr = NOP; m_valid = 0;
            m_hold.delete(); m_pc = br_target; m_halted = 0;
            if (m_out && !imem_rdy) m_stale = 1;
            else begin m_out = 0; m_stale = 0; end
            return;
        end
        acc = got && !m_stale;
        if (got) begin
            m_out = 0; m_stale = 0;
        end else if (req) begin
            m_out = 1; m_oaddr = a;
        end
        if (wrt_IF_ID) begin
            if (m_hold.size() > 0) begin
                {m_instr, m_pc2} = m_hold.pop_front();
                m_valid = 1;
                if (acc) m_hold.push_back({d, a + 16'd2});
            end else if (acc) begin
                m_instr = d; m_pc2 = a + 16'd2; m_valid = 1;
            end else begin
                m_instr = NOP; m_valid = 0;
            end
        end else if (acc) begin
            m_hold.push_back({d, a + 16'd2});
        end
        if (acc) begin
            if (d[15:11] == 5'b00000) m_halted = 1;
            else m_pc = m_pc + 16'd2;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit p, input bit w, input bit r,
                         input bit f, input logic [15:0] t);
        pause_pc = p; wrt_IF_ID = w; imem_rdy = r;
        flush = f; br_target = t;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        drive(0, 1, 1, 0, 16'h0);
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_bad++; $display("FAIL reset_req: got %b want 0", imem_req);
        end
        tick(); tick();
        n_cmp++;
        if ({instr_IF_ID, pc2_IF_ID, valid_IF_ID, halted} !== {NOP, 16'h0, 2'b00}) begin
            n_bad++;
            $display("FAIL reset_regs: got %h/%h/%b/%b want 0800/0000/0/0",
                     instr_IF_ID, pc2_IF_ID, valid_IF_ID, halted);
        end
    endtask

    task automatic test_stream();
        rst_n = 1;
        drive(0, 1, 1, 0, 16'h0);
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
            n_bad++; $display("FAIL stream_req: got %b/%h want 1/0000", imem_req, imem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({instr_IF_ID, pc2_IF_ID, valid_IF_ID} !== {mem[i], 16'(2*i+2), 1'b1}) begin
                n_bad++;
                $display("FAIL stream_%0d: got %h/%h/%b want %h/%h/1", i,
                         instr_IF_ID, pc2_IF_ID, valid_IF_ID, mem[i], 16'(2*i+2));
            end
        end
    endtask

    task automatic test_load_use();
        rst_n = 0; drive(0, 1, 1, 0, 16'h0); tick();
        rst_n = 1; drive(0, 1, 1, 0, 16'h0);
        tick(); tick();
        drive(1, 0, 1, 0, 16'h0);
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_bad++; $display("FAIL lu_req: got %b want 0", imem_req);
        end
        tick();
        n_cmp++;
        if ({instr_IF_ID, pc2_IF_ID, valid_IF_ID} !== {mem[1], 16'h0004, 1'b1}) begin
            n_bad++;
            $display("FAIL lu_hold: got %h/%h/%b want %h/0004/1",
                     instr_IF_ID, pc2_IF_ID, valid_IF_ID, mem[1]);
        end
        drive(0, 1, 1, 0, 16'h0);
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0004}) begin
            n_bad++; $display("FAIL lu_resume: got %b/%h want 1/0004", imem_req, imem_addr);
        end
        tick();
        n_cmp++;
        if ({instr_IF_ID, pc2_IF_ID, valid_IF_ID} !== {mem[2], 16'h0006, 1'b1}) begin
            n_bad++;
            $display("FAIL lu_next: got %h/%h/%b want %h/0006/1",
                     instr_IF_ID, pc2_IF_ID, valid_IF_ID, mem[2]);
        end
    endtask

    task automatic test_miss();
        drive(0, 1, 0, 1, 16'h0010);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0, 16'h0);
            n_cmp++;
            if ({imem_req, imem_addr} !== {1'b1, 16'h0010}) begin
                n_bad++;
                $display("FAIL miss_req_%0d: got %b/%h want 1/0010", i, imem_req, imem_addr);
            end
            tick();
            n_cmp++;
            if ({instr_IF_ID, valid_IF_ID} !== {NOP, 1'b0}) begin
                n_bad++;
                $display("FAIL miss_bubble_%0d: got %h/%b want 0800/0", i, instr_IF_ID, valid_IF_ID);
            end
        end
        drive(0, 1, 1, 0, 16'h0);
        tick();
        n_cmp++;
        if ({instr_IF_ID, pc2_IF_ID, valid_IF_ID} !== {mem[8], 16'h0012, 1'b1}) begin
            n_bad++;
            $display("FAIL miss_deliver: got %h/%h/%b want %h/0012/1",
                     instr_IF_ID, pc2_IF_ID, valid_IF_ID, mem[8]);
        end
    endtask

    task automatic test_hold();
        drive(0, 0, 1, 0, 16'h0);
        tick();
        n_cmp++;
        if ({instr_IF_ID, pc2_IF_ID, valid_IF_ID} !== {mem[8], 16'h0012, 1'b1}) begin
            n_bad++;
            $display("FAIL hold_ifid: got %h/%h/%b want %h/0012/1",
                     instr_IF_ID, pc2_IF_ID, valid_IF_ID, mem[8]);
        end
        drive(0, 0, 1, 0, 16'h0);
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_bad++; $display("FAIL hold_req: got %b want 0", imem_req);
        end
        tick();
        drive(0, 1, 1, 0, 16'h0);
        tick();
        n_cmp++;
        if ({instr_IF_ID, pc2_IF_ID, valid_IF_ID} !== {mem[9], 16'h0014, 1'b1}) begin
            n_bad++;
            $display("FAIL hold_drain: got %h/%h/%b want %h/0014/1",
                     instr_IF_ID, pc2_IF_ID, valid_IF_ID, mem[9]);
        end
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0014}) begin
            n_bad++; $display("FAIL hold_pc: got %b/%h want 1/0014", imem_req, imem_addr);
        end
        tick();
    endtask

    task automatic test_flush();
        drive(0, 1, 0, 0, 16'h0);
        tick(); tick();
        drive(0, 1, 0, 1, 16'h0040);
        tick();
        n_cmp++;
        if (valid_IF_ID !== 1'b0) begin
            n_bad++; $display("FAIL flush_bubble: got %b want 0", valid_IF_ID);
        end
        drive(0, 1, 0, 0, 16'h0);
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0016}) begin
            n_bad++; $display("FAIL drain_addr: got %b/%h want 1/0016", imem_req, imem_addr);
        end
        tick();
        drive(0, 1, 1, 0, 16'h0);
        tick();
        n_cmp++;
        if ({instr_IF_ID, valid_IF_ID} !== {NOP, 1'b0}) begin
            n_bad++; $display("FAIL drain_discard: got %h/%b want 0800/0", instr_IF_ID, valid_IF_ID);
        end
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0040}) begin
            n_bad++; $display("FAIL flush_target: got %b/%h want 1/0040", imem_req, imem_addr);
        end
        tick();
        n_cmp++;
        if ({instr_IF_ID, pc2_IF_ID, valid_IF_ID} !== {mem[32], 16'h0042, 1'b1}) begin
            n_bad++;
            $display("FAIL flush_fetch: got %h/%h/%b want %h/0042/1",
                     instr_IF_ID, pc2_IF_ID, valid_IF_ID, mem[32]);
        end
        drive(0, 0, 1, 0, 16'h0);
        tick();
        drive(0, 0, 1, 1, 16'h0060);
        tick();
        drive(0, 1, 1, 0, 16'h0);
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0060}) begin
            n_bad++; $display("FAIL flush_hold_req: got %b/%h want 1/0060", imem_req, imem_addr);
        end
        tick();
        n_cmp++;
        if ({instr_IF_ID, pc2_IF_ID, valid_IF_ID} !== {mem[48], 16'h0062, 1'b1}) begin
            n_bad++;
            $display("FAIL flush_hold_clear: got %h/%h/%b want %h/0062/1",
                     instr_IF_ID, pc2_IF_ID, valid_IF_ID, mem[48]);
        end
    endtask

    task automatic test_halt();
        logic [15:0] saved;
        saved  = mem[4];
        mem[4] = 16'h0123;
        drive(0, 1, 0, 1, 16'h0008);
        tick();
        drive(0, 1, 1, 0, 16'h0);
        tick();
        n_cmp++;
        if ({instr_IF_ID, pc2_IF_ID, valid_IF_ID, halted} !== {16'h0123, 16'h000A, 2'b11}) begin
            n_bad++;
            $display("FAIL halt_deliver: got %h/%h/%b/%b want 0123/000a/1/1",
                     instr_IF_ID, pc2_IF_ID, valid_IF_ID, halted);
        end
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_bad++; $display("FAIL halt_req: got %b want 0", imem_req);
        end
        tick();
        n_cmp++;
        if ({valid_IF_ID, halted, imem_req} !== 3'b010) begin
            n_bad++;
            $display("FAIL halt_stay: got v%b h%b r%b want v0 h1 r0", valid_IF_ID, halted, imem_req);
        end
        drive(0, 1, 1, 1, 16'h0020);
        tick();
        n_cmp++;
        if (halted !== 1'b0) begin
            n_bad++; $display("FAIL halt_exit: got %b want 0", halted);
        end
        drive(0, 1, 1, 0, 16'h0);
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0020}) begin
            n_bad++; $display("FAIL halt_resume: got %b/%h want 1/0020", imem_req, imem_addr);
        end
        tick();
        mem[4] = saved;
        drive(0, 1, 0, 0, 16'h0);
        tick(); tick();
        rst_n = 0;
        drive(0, 1, 1, 0, 16'h0);
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_bad++; $display("FAIL rst_wait_req: got %b want 0", imem_req);
        end
        tick();
        n_cmp++;
        if ({instr_IF_ID, pc2_IF_ID, valid_IF_ID, halted} !== {NOP, 16'h0, 2'b00}) begin
            n_bad++;
            $display("FAIL rst_wait_regs: got %h/%h/%b/%b want 0800/0000/0/0",
                     instr_IF_ID, pc2_IF_ID, valid_IF_ID, halted);
        end
        rst_n = 1;
        drive(0, 1, 1, 0, 16'h0);
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
            n_bad++; $display("FAIL rst_wait_pc: got %b/%h want 1/0000", imem_req, imem_addr);
        end
        tick();
    endtask

    task automatic test_wrap();
        drive(0, 1, 0, 1, 16'hFFFE);
        tick();
        drive(0, 1, 1, 0, 16'h0);
        tick();
        n_cmp++;
        if ({instr_IF_ID, pc2_IF_ID, valid_IF_ID} !== {mem[255], 16'h0000, 1'b1}) begin
            n_bad++;
            $display("FAIL wrap_pc2: got %h/%h/%b want %h/0000/1",
                     instr_IF_ID, pc2_IF_ID, valid_IF_ID, mem[255]);
        end
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
            n_bad++; $display("FAIL wrap_pc: got %b/%h want 1/0000", imem_req, imem_addr);
        end
    endtask

    task automatic test_random();
        logic [15:0] t;
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 99) < 4) mem[i][15:11] = 5'b00000;
        end
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            t = ($urandom_range(0, 19) == 0) ? 16'hFFFE
                                             : {7'd0, 8'($urandom_range(0, 255)), 1'b0};
            drive(1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
                  ($urandom_range(0, 19) == 0), t);
            n_cmp++;
            if (imem_req !== exp_req()) begin
                n_bad++; $display("FAIL rnd_req c%0d: got %b want %b", c, imem_req, exp_req());
            end
            if (exp_req()) begin
                n_cmp++;
                if (imem_addr !== exp_addr()) begin
                    n_bad++;
                    $display("FAIL rnd_addr c%0d: got %h want %h", c, imem_addr, exp_addr());
                end
            end
            tick();
            n_cmp++;
            if ({instr_IF_ID, valid_IF_ID, halted} !== {m_instr, m_valid, m_halted}) begin
                n_bad++;
                $display("FAIL rnd_ifid c%0d: got %h/%b/%b want %h/%b/%b", c,
                         instr_IF_ID, valid_IF_ID, halted, m_instr, m_valid, m_halted);
            end
            if (m_valid) begin
                n_cmp++;
                if (pc2_IF_ID !== m_pc2) begin
                    n_bad++;
                    $display("FAIL rnd_pc2 c%0d: got %h want %h", c, pc2_IF_ID, m_pc2);
                end
            end
        end
    endtask

    initial begin
        logic [15:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 16'($urandom);
            if (v[15:11] == 5'b00000) v[15:11] = 5'b00001;
            mem[i] = v;
        end
        rst_n = 0;
        drive(0, 1, 0, 0, 16'h0);
        test_reset();
        test_stream();
        test_load_use();
        test_miss();
        test_hold();
        test_flush();
        test_halt();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
